// File: rtl/apb_pkg.sv
// Purpose: shared types and widths for the APB3 initiator bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    // Default bus widths; the bridge takes these as parameter defaults.
    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Width of a counter that must hold values 0..n, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        int w;
        w = (n <= 0) ? 1 : $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Purpose: APB3 initiator; one APB transfer per valid/ready request, response returned on a valid/ready stream.
// Latency: request accepted in cycle N -> SETUP N+1, ACCESS N+2, response valid N+3 plus one cycle per wait state.
// Backpressure: req_ready_o only in IDLE; response held stable in RESP until rsp_ready_i, blocking new requests.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   req_valid_i/req_ready_o     request handshake; req_write_i, req_addr_i, req_wdata_i carry the request
//   rsp_valid_o/rsp_ready_i     response handshake; rsp_rdata_o, rsp_err_o, rsp_timeout_o carry the result
//   busy_o                      high whenever a transfer or response is in flight
//   PADDR..PSLVERR              APB3 initiator interface
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_AW         = APB_ADDR_W,
    parameter int APB_DW         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [APB_AW-1:0] req_addr_i,
    input  logic [APB_DW-1:0] req_wdata_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [APB_DW-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,

    output logic              busy_o,

    output logic [APB_AW-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int              CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Value the counter holds during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    apb_state_e       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             req_fire;

    assign req_ready_o = (state == IDLE) && !rst;
    assign busy_o      = (state != IDLE);
    assign req_fire    = req_valid_i && req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            PWRITE        <= 1'b0;
            PADDR         <= '0;
            PWDATA        <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= '0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Address/data/direction only move on acceptance, so the
                    // bus stays quiet between transfers.
                    if (req_fire) begin
                        PADDR   <= req_addr_i;
                        PWDATA  <= req_wdata_i;
                        PWRITE  <= req_write_i;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // A completing PREADY wins over the watchdog in the same cycle.
                    if (PREADY) begin
                        rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
                        rsp_err_o     <= PSLVERR;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        state         <= RESP;
                    end else if (TIMEOUT_EN && (tmo_cnt == CNT_LAST)) begin
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        state         <= RESP;
                    end else if (tmo_cnt != CNT_MAX) begin
                        // Saturating: with the watchdog disabled the count
                        // parks at all-ones instead of wrapping.
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // PENABLE is low here and in the following IDLE cycle,
                    // giving the slave a clean falling edge per transfer.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: self-checking bench for apb_master_bridge with a behavioural APB slave.
// Latency: n/a.
// Backpressure: exercised via held rsp_ready_i and held req_valid_i sequences.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready_o, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid_o, rsp_ready;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, rsp_timeout_o, busy_o;
    logic [9:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    apb_master_bridge #(.APB_AW(10), .APB_DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural slave: PREADY after slv_waits wait states; random noise on
    // PREADY/PSLVERR/PRDATA outside ACCESS, which the bridge must ignore.
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    bit          slv_err   = 1'b0;
    int          acc_cnt   = 0;
    logic [31:0] noise     = '0;

    always @(negedge clk) noise <= $urandom;

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    always_comb begin
        pready  = noise[0];
        pslverr = noise[1];
        prdata  = noise;
        if (psel && penable) begin
            pready  = (acc_cnt == slv_waits);
            pslverr = slv_err;
            prdata  = slv_rdata;
        end
    end

    // PENABLE must stay low at least two cycles between transfers.
    int   low_run  = 2;
    logic pen_prev = 1'b0;
    always @(negedge clk) begin
        if (penable && !pen_prev) chk("penable_gap", (low_run >= 2), 1);
        if (penable) low_run = 0;
        else         low_run++;
        pen_prev = penable;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic run_txn(input apb_req_t req, input int waits, input logic [31:0] prd,
                           input bit serr, input int hold,
                           output apb_rsp_t rsp, output int lat, output int pen_cnt,
                           output bit stable_ok, output bit hold_ok);
        int n;
        slv_waits = waits;
        slv_rdata = prd;
        slv_err   = serr;
        req_write = req.write;
        req_addr  = req.addr;
        req_wdata = req.wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", req_ready_o, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("setup_phase", {busy_o, psel, penable}, 3'b110);
        lat = 1;
        pen_cnt = 0;
        stable_ok = 1'b1;
        while (!rsp_valid_o && lat < 100) begin
            if (penable) pen_cnt++;
            if (psel && (paddr !== req.addr || pwrite !== req.write ||
                         (req.write && pwdata !== req.wdata)))
                stable_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("resp_phase", {rsp_valid_o, psel, penable}, 3'b100);
        rsp.rdata   = rsp_rdata_o;
        rsp.err     = rsp_err_o;
        rsp.timeout = rsp_timeout_o;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_rdata_o !== rsp.rdata || rsp_err_o !== rsp.err ||
                rsp_timeout_o !== rsp.timeout || req_ready_o || psel || penable)
                hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("consume", {rsp_valid_o, busy_o, req_ready_o}, 3'b001);
    endtask

    typedef struct {
        apb_req_t    req;
        int          waits;
        logic [31:0] prd;
        bit          serr;
        int          hold;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(bit w, logic [9:0] a, logic [31:0] wd, int waits,
                                logic [31:0] prd, bit serr, int hold,
                                logic [31:0] er, bit ee, bit et, int el);
        vec_t v;
        v.req.write = w;  v.req.addr = a;  v.req.wdata = wd;
        v.waits = waits;  v.prd = prd;     v.serr = serr;    v.hold = hold;
        v.exp_rdata = er; v.exp_err = ee;  v.exp_to = et;    v.exp_lat = el;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        apb_rsp_t rsp;
        apb_req_t rq;
        int lat, pen, n, waits, hold, acc;
        bit st_ok, hd_ok, serr, exp_to;
        logic [31:0] prd, exp_rd;

        // w, addr, wdata, waits, prdata, slverr, hold -> rdata, err, timeout, cycles-to-rsp
        vecs[0] = mk(1, 10'h000, 32'h0000_0001,  0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0,  3);
        vecs[1] = mk(0, 10'h004, 32'h0,          3, 32'h0000_00A5, 0, 0, 32'h0000_00A5, 0, 0,  6);
        vecs[2] = mk(1, 10'h014, 32'h0000_0055,  1, 32'h1111_1111, 1, 1, 32'h0,         1, 0,  4);
        vecs[3] = mk(0, 10'h008, 32'h0,         20, 32'h1234_5678, 0, 2, 32'h0,         1, 1, 10);
        vecs[4] = mk(0, 10'h3FE, 32'h0,          7, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 0, 0, 10);
        vecs[5] = mk(1, 10'h3FC, 32'hA5A5_5A5A,  2, 32'hFFFF_FFFF, 0, 3, 32'h0,         0, 0,  5);
        vecs[6] = mk(0, 10'h010, 32'h0,          6, 32'h8000_0001, 0, 0, 32'h8000_0001, 0, 0,  9);
        vecs[7] = mk(0, 10'h0C0, 32'h0,          8, 32'h7777_7777, 0, 1, 32'h0,         1, 1, 10);

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
        chk("reset_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}, '0);
        chk("reset_busy_ready", {busy_o, req_ready_o}, 2'b00);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", req_ready_o, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].req, vecs[i].waits, vecs[i].prd, vecs[i].serr, vecs[i].hold,
                    rsp, lat, pen, st_ok, hd_ok);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_penable_cycles", i), pen, vecs[i].exp_lat - 2);
            chk($sformatf("vec%0d_rdata", i), rsp.rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err_timeout", i), {rsp.err, rsp.timeout},
                {vecs[i].exp_err, vecs[i].exp_to});
            chk($sformatf("vec%0d_bus_stable", i), st_ok, 1);
            chk($sformatf("vec%0d_rsp_hold", i), hd_ok, 1);
        end

        // Backpressure: next request held valid while the response waits 5 cycles.
        slv_waits = 0; slv_rdata = 32'h0BAD_F00D; slv_err = 1'b0;
        req_write = 1'b0; req_addr = 10'h020; req_wdata = '0; req_valid = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
        chk("bp_accept_a", req_ready_o, 1);
        @(negedge clk);
        chk("bp_paddr_a", {psel, paddr}, {1'b1, 10'h020});
        req_write = 1'b1; req_addr = 10'h024; req_wdata = 32'h1357_9BDF;
        n = 0;
        while (!rsp_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("bp_rsp_a", {rsp_valid_o, rsp_rdata_o, rsp_err_o}, {1'b1, 32'h0BAD_F00D, 1'b0});
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {rsp_valid_o, rsp_rdata_o, req_ready_o, psel},
                {1'b1, 32'h0BAD_F00D, 1'b0, 1'b0});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_ready_after_consume", {req_ready_o, rsp_valid_o}, 2'b10);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_setup_b", {psel, penable, pwrite, paddr, pwdata},
            {1'b1, 1'b0, 1'b1, 10'h024, 32'h1357_9BDF});
        n = 0;
        while (!rsp_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("bp_rsp_b", {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {1'b1, 32'h0, 2'b00});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the middle of ACCESS.
        slv_waits = 30;
        req_write = 1'b0; req_addr = 10'h030; req_valid = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!penable && n < 100) begin @(negedge clk); n++; end
        chk("mid_access_reached", {psel, penable}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {psel, penable, rsp_valid_o, busy_o, req_ready_o}, 5'b00000);
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready_o, 1);
        @(negedge clk);
        chk("midrst_idle", {psel, penable, busy_o, rsp_valid_o}, 4'b0000);

        // Randomized traffic against a transaction-level model.
        for (int i = 0; i < 40; i++) begin
            rq.write = 1'($urandom_range(0, 1));
            rq.addr  = 10'($urandom_range(0, 1023));
            rq.wdata = $urandom;
            waits    = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(6, 12);
            prd      = $urandom;
            serr     = rq.write && ($urandom_range(0, 3) == 0);
            hold     = $urandom_range(0, 3);
            // Model: waits+1 ACCESS cycles, capped at TO by the watchdog.
            exp_to   = (waits + 1 > TO);
            acc      = exp_to ? TO : waits + 1;
            exp_rd   = (exp_to || rq.write) ? 32'h0 : prd;
            run_txn(rq, waits, prd, serr, hold, rsp, lat, pen, st_ok, hd_ok);
            chk($sformatf("rnd%0d_latency", i), lat, 2 + acc);
            chk($sformatf("rnd%0d_penable_cycles", i), pen, acc);
            chk($sformatf("rnd%0d_rsp", i), {rsp.rdata, rsp.err, rsp.timeout},
                {exp_rd, (exp_to | serr), exp_to});
            chk($sformatf("rnd%0d_stable", i), {st_ok, hd_ok}, 2'b11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 initiator that turns a simple valid/ready request/response stream into APB transfers.
- It is the other end of the Ascon APB register block. A test controller or UART/SPI command bridge drives key/nonce/ctrl writes, AD/PT pushes, status polls and CT pops through it.
- Executes exactly one APB transfer per request, with wait-state support, slave-error forwarding and a watchdog timeout.

Parameters:
- APB_AW, 10, APB address width.
- APB_DW, 32, APB data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  APB_AW  byte address, forwarded unmodified
- req_wdata_i  in  APB_DW  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  APB_DW  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  PSLVERR sampled high, or timeout
- rsp_timeout_o  out  1  transfer aborted by the watchdog
- busy_o  out  1  state is not IDLE
- PADDR  out  APB_AW  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  APB_DW  APB write data
- PRDATA  in  APB_DW  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: single clock domain. While rst is high at an edge, all registers reset:
  - state = IDLE
  - PSEL, PENABLE, PWRITE = 0
  - PADDR, PWDATA = 0
  - rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_rdata_o = 0
  - timeout counter = 0
- req_ready_o = (state == IDLE) && !rst. busy_o = (state != IDLE).
- State machine, IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
  - IDLE: on req_valid_i && req_ready_o, register addr, wdata and write into PADDR, PWDATA and PWRITE, then go to SETUP.
  - SETUP (one cycle): PSEL = 1, PENABLE = 0. Next state is ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1, with PADDR, PWDATA and PWRITE held stable.
    - If PREADY = 1: capture rsp_rdata_o = PWRITE ? 0 : PRDATA, rsp_err_o = PSLVERR, rsp_timeout_o = 0. Go to RESP.
    - Else if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1: rsp_rdata_o = 0, rsp_err_o = 1, rsp_timeout_o = 1. Go to RESP.
    - Otherwise increment the counter.
  - RESP: PSEL = 0, PENABLE = 0, rsp_valid_o = 1. Response fields stay stable until rsp_ready_i = 1; then go to IDLE and clear rsp_valid_o and the counter.
- Latency, for a request accepted in cycle N:
  - SETUP in N+1, ACCESS in N+2.
  - With zero wait states, rsp_valid_o rises in N+3.
  - With rsp_ready_i = 1 in N+3, the next request can be accepted in N+4.
  - Each wait state adds one cycle.
- PENABLE is always low for at least two cycles between transfers. This guarantees the slave's end-of-transaction pulse (PENABLE falling) for every transfer.
- PADDR, PWDATA and PWRITE keep their last values outside transfers; there is no toggling while idle.
- Unaligned or out-of-range addresses are not filtered; the slave's PSLVERR is reported.
- PREADY and PSLVERR are ignored outside ACCESS.
- Timeout counter: width $clog2(TIMEOUT_CYCLES + 1), minimum 1. It saturates and never wraps.
- Reset mid-transfer: at the edge where rst = 1, PSEL and PENABLE drop and any pending response is discarded. req_ready_o = 1 in the first cycle after rst falls.
- rsp_ready_i asserted while rsp_valid_o = 0 has no effect.

Decomposition:
- Shared package apb_pkg holds:
  - apb_state_e (IDLE, SETUP, ACCESS, RESP)
  - apb_req_t {write, addr, wdata}
  - apb_rsp_t {rdata, err, timeout}
  - data and address widths as package parameters
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
- Write: addr 0x000, wdata 0x00000001, PREADY tied 1, request accepted in cycle N -> PSEL = 1 in N+1, PENABLE = 1 in N+2, rsp_valid_o in N+3 with err = 0 and rdata = 0.
- Read: addr 0x004, PREADY low for 3 ACCESS cycles, PRDATA = 0x000000A5 -> PENABLE high for 4 cycles, PADDR stable throughout, rsp_rdata_o = 0x000000A5, err = 0.
- Slave error: write to 0x014 with PSLVERR = 1 at PREADY -> rsp_err_o = 1, rsp_timeout_o = 0.
- Timeout: TIMEOUT_CYCLES = 8, PREADY stuck 0 -> after exactly 8 ACCESS cycles PSEL and PENABLE drop; rsp err = 1, timeout = 1, rdata = 0.
- Backpressure: rsp_ready_i low for 5 cycles with req_valid_i held high -> response fields stable, req_ready_o = 0, no new PSEL. The new request is accepted the cycle after the response is consumed.
- Reset mid-ACCESS: rst = 1 for 1 cycle -> next edge PSEL = PENABLE = 0, rsp_valid_o = 0, busy_o = 0; req_ready_o = 1 the cycle after rst falls.
